// File: rtl/sq_norm_sched.sv
// Round-robin scheduler sharing one 1-cycle squarer among N_REQ requesters;
// sequences x, y, z through it and returns the saturated sum of squares.
module sq_norm_sched #(
  parameter int WIDTH  = 32,
  parameter int Q_BITS = 16,
  parameter int N_REQ  = 2,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ*3*WIDTH-1:0] req_vec_i,
  output logic                     sq_start_o,
  output logic [WIDTH-1:0]         sq_a_o,
  input  logic                     sq_valid_i,
  input  logic [2*WIDTH-1:0]       sq_result_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [ID_W-1:0]          res_id_o,
  output logic [WIDTH-1:0]         res_len_sq_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic signed [WIDTH-1:0]   MAX_V    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0]     MAX_SUM  = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] MAX_WIDE = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         rr_q, rr_d;
  logic [1:0]              issue_cnt_q, issue_cnt_d;
  logic [1:0]              recv_cnt_q, recv_cnt_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic [3*WIDTH-1:0]      vec_q, vec_d;
  logic [ID_W-1:0]         id_q, id_d;

  logic [N_REQ-1:0]          grant_oh;
  logic [ID_W-1:0]           grant_idx;
  logic                      grant_any;
  logic                      req_hs;
  logic                      accum_en;
  int                        scan_idx;
  logic signed [2*WIDTH-1:0] term_full;
  logic signed [WIDTH-1:0]   term_c;
  logic signed [WIDTH:0]     sum_w;
  logic signed [WIDTH-1:0]   acc_sat;

  // First valid requester at or after the rr pointer, wrapping around.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = (int'(rr_q) + k) % N_REQ;
      if (!grant_any && req_valid_i[scan_idx]) begin
        grant_any          = 1'b1;
        grant_oh[scan_idx] = 1'b1;
        grant_idx          = ID_W'(scan_idx);
      end
    end
  end

  assign req_hs   = (state_q == S_IDLE) && grant_any;
  assign accum_en = sq_valid_i && ((state_q == S_ISSUE) || (state_q == S_WAIT));

  always_comb begin
    term_full = $signed(sq_result_i) >>> Q_BITS;
    term_c    = (term_full > MAX_WIDE) ? MAX_V : term_full[WIDTH-1:0];
    sum_w     = {acc_q[WIDTH-1], acc_q} + {term_c[WIDTH-1], term_c};
    acc_sat   = (sum_w > MAX_SUM) ? MAX_V : sum_w[WIDTH-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      acc_q       <= '0;
      vec_q       <= '0;
      id_q        <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      acc_q       <= acc_d;
      vec_q       <= vec_d;
      id_q        <= id_d;
    end
  end

  // WAIT exits on the cycle the third square lands, so DONE follows with no bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_hs) state_d = S_ISSUE;
      S_ISSUE: if (issue_cnt_q == 2'd2) state_d = S_WAIT;
      S_WAIT:  if ((recv_cnt_q == 2'd3) || (sq_valid_i && (recv_cnt_q == 2'd2))) state_d = S_DONE;
      S_DONE:  if (res_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rr_d        = rr_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    acc_d       = acc_q;
    vec_d       = vec_q;
    id_d        = id_q;
    if (req_hs) begin
      vec_d       = req_vec_i[grant_idx*3*WIDTH +: 3*WIDTH];
      id_d        = grant_idx;
      acc_d       = '0;
      issue_cnt_d = '0;
      recv_cnt_d  = '0;
      rr_d        = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
    if (state_q == S_ISSUE) issue_cnt_d = issue_cnt_q + 2'd1;
    if (accum_en) begin
      acc_d      = acc_sat;
      recv_cnt_d = recv_cnt_q + 2'd1;
    end
  end

  always_comb begin
    req_ready_o  = (state_q == S_IDLE) ? grant_oh : '0;
    sq_start_o   = (state_q == S_ISSUE);
    sq_a_o       = '0;
    if (state_q == S_ISSUE) begin
      case (issue_cnt_q)
        2'd0:    sq_a_o = vec_q[WIDTH-1:0];
        2'd1:    sq_a_o = vec_q[2*WIDTH-1:WIDTH];
        default: sq_a_o = vec_q[3*WIDTH-1:2*WIDTH];
      endcase
    end
    res_valid_o  = (state_q == S_DONE);
    res_id_o     = id_q;
    res_len_sq_o = acc_q;
  end

endmodule

// File: tb/tb_sq_norm_sched.sv
// Directed bench for sq_norm_sched with a behavioural 1-cycle squarer.
module tb_sq_norm_sched;
  localparam int W = 32;
  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*3*W-1:0] req_vec;
  logic            sq_start;
  logic [W-1:0]    sq_a;
  logic            sq_valid;
  logic [2*W-1:0]  sq_result;
  logic            res_valid;
  logic            res_ready;
  logic [0:0]      res_id;
  logic [W-1:0]    res_len_sq;

  logic            sq_v_q = 1'b0;
  logic [2*W-1:0]  sq_r_q = '0;
  logic            stray;
  logic [2*W-1:0]  stray_val;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sq_norm_sched #(.WIDTH(W), .Q_BITS(16), .N_REQ(N)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_vec_i(req_vec),
    .sq_start_o(sq_start), .sq_a_o(sq_a),
    .sq_valid_i(sq_valid), .sq_result_i(sq_result),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_id_o(res_id), .res_len_sq_o(res_len_sq)
  );

  always @(posedge clk) begin
    sq_v_q <= sq_start;
    sq_r_q <= $signed({{W{sq_a[W-1]}}, sq_a}) * $signed({{W{sq_a[W-1]}}, sq_a});
  end
  assign sq_valid  = sq_v_q | stray;
  assign sq_result = stray ? stray_val : sq_r_q;

  typedef struct {
    int         id;
    logic [W-1:0] x, y, z, len;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int id, input logic [W-1:0] x, y, z);
    req_vec[id*3*W +: 3*W] = {z, y, x};
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, ".req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, ".sq_start"}, 64'(sq_start), 64'd0);
    chk({tag, ".sq_a"}, 64'(sq_a), 64'd0);
    chk({tag, ".res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, ".res_id"}, 64'(res_id), 64'd0);
    chk({tag, ".res_len_sq"}, 64'(res_len_sq), 64'd0);
  endtask

  // Accept at cycle 0, issue at 1..3, result at 5, handshake at 5.
  task automatic run_txn(input int id, input logic [W-1:0] x, y, z, input logic [W-1:0] exp_len);
    logic [W-1:0] comp [3];
    comp[0] = x; comp[1] = y; comp[2] = z;
    @(negedge clk);
    set_vec(id, x, y, z);
    req_valid = N'(1) << id;
    #1;
    chk("grant", 64'(req_ready), 64'(N'(1) << id));
    @(negedge clk);
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      chk("sq_start", 64'(sq_start), 64'd1);
      chk($sformatf("sq_a[%0d]", k), 64'(sq_a), 64'(comp[k]));
      @(negedge clk);
    end
    chk("res_valid_early", 64'(res_valid), 64'd0);
    @(negedge clk);
    chk("res_valid", 64'(res_valid), 64'd1);
    chk("res_id", 64'(res_id), 64'(id));
    chk("res_len_sq", 64'(res_len_sq), 64'(exp_len));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_after_hs", 64'(res_valid), 64'd0);
    $display("txn id=%0d x=%h y=%h z=%h exp_len=%h", id, x, y, z, exp_len);
  endtask

  initial begin
    int nres, viol, last_cyc;
    int ids[4];
    logic [W-1:0] lens[4];
    int cyc[4];
    logic [W-1:0] hold_len;

    tbl[0] = '{0, 32'h0001_0000, 32'h0002_0000, 32'h0002_0000, 32'h0009_0000};
    tbl[1] = '{1, 32'hFFFD_0000, 32'h0000_0000, 32'h0004_0000, 32'h0019_0000};
    tbl[2] = '{0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    tbl[3] = '{1, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_C000};
    tbl[4] = '{0, 32'h0001_8000, 32'h0001_8000, 32'h0001_8000, 32'h0006_C000};
    tbl[5] = '{1, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0003_0000};

    rst_n = 1'b0; req_valid = '0; req_vec = '0; res_ready = 1'b0;
    stray = 1'b0; stray_val = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++)
      run_txn(tbl[t].id, tbl[t].x, tbl[t].y, tbl[t].z, tbl[t].len);

    // Both requesters held valid: grants must alternate at 6-cycle spacing.
    @(negedge clk);
    set_vec(0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    set_vec(1, 32'h0001_0000, 32'h0002_0000, 32'h0002_0000);
    req_valid = 2'b11; res_ready = 1'b1;
    nres = 0; viol = 0;
    for (int c = 0; c < 40 && nres < 4; c++) begin
      #1;
      if ($countones(req_ready) > 1) viol++;
      if (res_valid && res_ready) begin
        ids[nres] = int'(res_id); lens[nres] = res_len_sq; cyc[nres] = c;
        nres++;
        if (nres == 4) req_valid = '0;
      end
      @(negedge clk);
    end
    res_ready = 1'b0; req_valid = '0;
    chk("alt.count", 64'(nres), 64'd4);
    chk("alt.onehot_viol", 64'(viol), 64'd0);
    last_cyc = -1;
    for (int i = 0; i < nres; i++) begin
      chk($sformatf("alt.id[%0d]", i), 64'(ids[i]), 64'(i % 2));
      chk($sformatf("alt.len[%0d]", i), 64'(lens[i]), (i % 2) ? 64'h0009_0000 : 64'h0003_0000);
      if (i > 0) chk($sformatf("alt.spacing[%0d]", i), 64'(cyc[i] - last_cyc), 64'd6);
      last_cyc = cyc[i];
      $display("alt result %0d id=%0d len=%h cycle=%0d", i, ids[i], lens[i], cyc[i]);
    end

    // Backpressure in DONE with a stray squarer pulse that must be ignored.
    @(negedge clk);
    set_vec(0, 32'h0001_0000, 32'h0002_0000, 32'h0002_0000);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("hold.res_valid_start", 64'(res_valid), 64'd1);
    hold_len = 32'h0009_0000;
    req_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("hold.res_valid", 64'(res_valid), 64'd1);
      chk("hold.res_id", 64'(res_id), 64'd0);
      chk("hold.res_len_sq", 64'(res_len_sq), 64'(hold_len));
      chk("hold.req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      stray = (c == 4); stray_val = 64'h0000_0004_0000_0000;
    end
    stray = 1'b0;
    req_valid = '0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("hold.released", 64'(res_valid), 64'd0);
    @(negedge clk);
    chk("hold.single_hs", 64'(res_valid), 64'd0);
    chk("hold.idle_sq_start", 64'(sq_start), 64'd0);
    $display("hold sequence done");

    // Reset during the second ISSUE cycle, stray result after release.
    @(negedge clk);
    set_vec(0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b1; stray_val = 64'h0000_0004_0000_0000;
    @(negedge clk);
    stray = 1'b0;
    chk_outputs_zero("post_reset");
    repeat (2) @(negedge clk);
    chk("post_reset.len", 64'(res_len_sq), 64'd0);
    run_txn(0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0003_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/sq_norm_sched.md
Name: sq_norm_sched

Overview:
- Shares one 1-cycle fixed-point squarer between N_REQ ray/direction units that need |v|^2 for normalization.
- Arbitrates requests round-robin and sequences x, y, z through the squarer.
- Accumulates the three squares with saturation and returns the length-squared tagged with the requester id.
- Sits between the ray-generation units and the normalization reciprocal-sqrt stage.

Parameters:
- WIDTH, 32: signed fixed-point word width of components and result.
- Q_BITS, 16: fractional bits (Q16.16 by default).
- N_REQ, 2: number of requesters, must be 2 or more.
- ID_W, $clog2(N_REQ): width of the requester id.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; state cleared while 0.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept (one-hot or zero).
- req_vec  in  N_REQ*3*WIDTH  per-requester {z,y,x}, signed Q format; requester i occupies bits [i*3*WIDTH +: 3*WIDTH].
- sq_start  out  1  start pulse to shared squarer.
- sq_a  out  WIDTH  signed operand to squarer.
- sq_valid  in  1  squarer result valid, 1 cycle after sq_start.
- sq_result  in  2*WIDTH  full unshifted product a*a from squarer.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accept.
- res_id  out  ID_W  requester index of the result.
- res_len_sq  out  WIDTH  x^2+y^2+z^2 in Q format, saturated.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rr pointer=0, issue and receive counters=0, accumulator=0. Outputs: req_ready=0, sq_start=0, sq_a=0, res_valid=0, res_id=0, res_len_sq=0.
- FSM IDLE:
  - req_ready is combinational, one-hot to the first requester with req_valid set, scanning from the rr pointer upward with wrap.
  - On handshake: latch vector and id, clear accumulator, clear both counters, go ISSUE. rr pointer <= grant+1 mod N_REQ.
  - Otherwise stay in IDLE.
- FSM ISSUE:
  - Runs exactly 3 cycles.
  - sq_start=1 with sq_a = x, then y, then z on consecutive cycles.
  - After z is issued, go WAIT.
- FSM WAIT:
  - Stays until the receive count reaches 3, then go DONE.
- Result accumulation, applied on every sq_valid while in ISSUE or WAIT:
  - term = sq_result >> Q_BITS (arithmetic shift).
  - If term > 2^(WIDTH-1)-1, clamp to 2^(WIDTH-1)-1.
  - acc <= min(acc+term, 2^(WIDTH-1)-1).
  - Receive count increments.
- FSM DONE:
  - res_valid=1; res_id and res_len_sq (=acc) are registered and stable until handshake.
  - On res_valid&res_ready: res_valid<=0 next cycle, go IDLE. No new grant in the same cycle.
- req_ready is 0 in every state except IDLE.
- Timing with a 1-cycle squarer:
  - Accept at cycle 0; issue x, y, z at cycles 1, 2, 3.
  - sq_valid at cycles 2, 3, 4; res_valid at cycle 5.
  - Throughput: one vector per 6 cycles when res_ready is held high.
- sq_valid while IDLE or DONE is ignored: no accumulation, no count change.
- A sq_valid that arrives late is still counted; WAIT has no timeout.
- res_ready while res_valid=0 is ignored.
- Reset mid-operation discards the in-flight vector. A squarer result that arrives after reset release lands in IDLE and is ignored.
- Inputs are squared as signed values, so negative components give positive squares. Accumulation never wraps.

Test Plan:
- Req0 vec x=0x00010000, y=0x00020000, z=0x00020000 (1,2,2) -> res_valid 5 cycles after accept, res_id=0, res_len_sq=0x00090000.
- Req1 vec (-3.0, 0, 4.0) = 0xFFFD0000, 0, 0x00040000 -> res_id=1, res_len_sq=0x00190000; sq_a sequence is 0xFFFD0000, 0x0, 0x00040000.
- Req0 vec x=y=z=0x7FFFFFFF -> res_len_sq=0x7FFFFFFF (saturated), no wrap.
- Both req_valid held high, res_ready=1, 4 transactions -> grants and res_id alternate 0,1,0,1; req_ready never has more than one bit set.
- Hold res_ready=0 for 10 cycles in DONE -> res_valid, res_id, res_len_sq stable and req_ready=0 throughout; release gives one handshake, then IDLE.
- Assert reset low during the second ISSUE cycle, release 2 cycles later with a stray sq_valid pulse -> all outputs 0, state IDLE, next request (1,1,1) gives 0x00030000.
